// File: rtl/simplez_tx_arb.sv
// Two-requester arbiter for the Simplez UART transmitter: round-robin grant, byte latch, start/ready handshake.
// Define SIMPLEZ_TXARB_FIXED_PRIO_EN to make requester 0 always win instead of round-robin.
module simplez_tx_arb #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy,
  output logic       owner
);

  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_GAP       = 3'd4
  } state_t;

  state_t        r_state;
  logic [GW-1:0] r_gap_cnt;
  logic          r_owner;
  logic          r_tx_start;
  logic          r_ack0;
  logic          r_ack1;
  logic          r_busy;
  logic [7:0]    r_tx_data;

  logic w_any_req;
  logic w_grant1;

  assign w_any_req = req0 | req1;

`ifdef SIMPLEZ_TXARB_FIXED_PRIO_EN
  assign w_grant1 = ~req0;
`else
  // On a tie the requester that did not own the last grant wins.
  assign w_grant1 = (req0 & req1) ? ~r_owner : req1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_gap_cnt  <= '0;
      r_owner    <= 1'b1;
      r_tx_start <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_start <= 1'b0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_ready && w_any_req) begin
            r_state    <= S_START;
            r_owner    <= w_grant1;
            r_tx_data  <= w_grant1 ? data1 : data0;
            r_tx_start <= 1'b1;
            r_ack0     <= ~w_grant1;
            r_ack1     <= w_grant1;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (!tx_ready) begin
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (tx_ready) begin
            if (GAP_CYCLES > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LOAD;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - GW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign busy     = r_busy;
  assign owner    = r_owner;

endmodule

// File: tb/tb_simplez_tx_arb.sv
// Bench for simplez_tx_arb: unit a (no gap) covers grant/tie/reset/abort, unit b (gap of 5) covers spacing.
module tb_simplez_tx_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_a, req1_a, ack0_a, ack1_a, tx_start_a, tx_ready_a, busy_a, owner_a;
  logic [7:0] data0_a, data1_a, tx_data_a;
  logic       req0_b, req1_b, ack0_b, ack1_b, tx_start_b, tx_ready_b, busy_b, owner_b;
  logic [7:0] data0_b, data1_b, tx_data_b;

  simplez_tx_arb #(.GAP_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_a), .data0(data0_a), .ack0(ack0_a),
    .req1(req1_a), .data1(data1_a), .ack1(ack1_a),
    .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_ready(tx_ready_a),
    .busy(busy_a), .owner(owner_a)
  );

  simplez_tx_arb #(.GAP_CYCLES(5)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_b), .data0(data0_b), .ack0(ack0_b),
    .req1(req1_b), .data1(data1_b), .ack1(ack1_b),
    .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_ready(tx_ready_b),
    .busy(busy_b), .owner(owner_b)
  );

  // UART models: ready drops the cycle after a start and stays low for a 20-clock frame.
  int   ucnt_a = 0;
  int   ucnt_b = 0;
  logic block_a = 1'b0;
  always @(posedge clk) begin
    if (tx_start_a) ucnt_a <= 20;
    else if (ucnt_a != 0) ucnt_a <= ucnt_a - 1;
  end
  always @(posedge clk) begin
    if (tx_start_b) ucnt_b <= 20;
    else if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
  end
  assign tx_ready_a = (ucnt_a == 0) && !block_a;
  assign tx_ready_b = (ucnt_b == 0);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    logic       who;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic push_exp(input logic who, input logic [7:0] d);
    exp_t e;
    e.who  = who;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor for unit a
  always @(negedge clk) begin
    if (!rst) begin
      if (ack0_a | ack1_a) begin
        check_eq("ack_has_start", tx_start_a, 1);
        check_eq("ack_exclusive", ack0_a & ack1_a, 0);
      end
      if (tx_start_a) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_start", tx_start_a, 0);
        end else begin
          mon_e = exp_q.pop_front();
          $display("TX a owner=%0d ack0=%0d ack1=%0d data=%02h", owner_a, ack0_a, ack1_a, tx_data_a);
          check_eq("sb_tx_data", tx_data_a, mon_e.data);
          check_eq("sb_ack0", ack0_a, !mon_e.who);
          check_eq("sb_ack1", ack1_a, mon_e.who);
          check_eq("sb_owner", owner_a, mon_e.who);
        end
      end
    end
  end

  task automatic wait_start_a(input int max);
    int n = 0;
    while (!tx_start_a && n < max) begin
      @(negedge clk);
      n++;
    end
    if (!tx_start_a) check_eq("start_timeout_a", tx_start_a, 1);
  endtask

  task automatic wait_idle_a(input int max);
    int n = 0;
    while ((busy_a || !tx_ready_a) && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy_a || !tx_ready_a) check_eq("idle_timeout_a", busy_a, 0);
  endtask

  task automatic check_reset_a(input string tag);
    check_eq({tag, "_tx_start"}, tx_start_a, 0);
    check_eq({tag, "_ack0"}, ack0_a, 0);
    check_eq({tag, "_ack1"}, ack1_a, 0);
    check_eq({tag, "_tx_data"}, tx_data_a, 8'h00);
    check_eq({tag, "_busy"}, busy_a, 0);
    check_eq({tag, "_owner"}, owner_a, 1);
  endtask

  initial begin
    int n;
    int r;
    int s;
    rst = 1'b1;
    req0_a = 0; req1_a = 0; data0_a = 0; data1_a = 0;
    req0_b = 0; req1_b = 0; data0_b = 0; data1_b = 0;
    repeat (3) @(negedge clk);
    check_reset_a("rst");
    check_eq("rst_busy_b", busy_b, 0);
    check_eq("rst_owner_b", owner_b, 1);
    rst = 1'b0;

    // Single byte: start and ack0 one cycle after the request
    @(negedge clk);
    req0_a = 1; data0_a = 8'h41;
    push_exp(1'b0, 8'h41);
    @(negedge clk);
    check_eq("t1_start_latency", tx_start_a, 1);
    check_eq("t1_ack0", ack0_a, 1);
    req0_a = 0; data0_a = 8'h00;
    @(negedge clk);
    n = 0;
    while (!tx_ready_a && n < 100) begin
      check_eq("t1_busy_frame", busy_a, 1);
      @(negedge clk);
      n++;
    end
    check_eq("t1_ready_rose", tx_ready_a, 1);
    check_eq("t1_busy_last", busy_a, 1);
    @(negedge clk);
    check_eq("t1_idle", busy_a, 0);
    check_eq("t1_tx_data_hold", tx_data_a, 8'h41);

    // Tie with both requests held, starting from reset ownership
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("t2_owner_rst", owner_a, 1);
    req0_a = 1; data0_a = 8'h30;
    req1_a = 1; data1_a = 8'hA5;
`ifdef SIMPLEZ_TXARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push_exp(1'b0, 8'h30);
`else
    for (int i = 0; i < 2; i++) begin
      push_exp(1'b0, 8'h30);
      push_exp(1'b1, 8'hA5);
    end
`endif
    for (int i = 0; i < 4; i++) begin
      wait_start_a(100);
      if (i < 3) @(negedge clk);
    end
    req0_a = 0; req1_a = 0;
    @(negedge clk);
    wait_idle_a(100);
    check_eq("t2_drained", exp_q.size(), 0);

    // Reset during WAIT_DONE while req1 is held
    req1_a = 1; data1_a = 8'h5A;
    push_exp(1'b1, 8'h5A);
    push_exp(1'b1, 8'h5A);
    wait_start_a(50);
    @(negedge clk);
    @(negedge clk);
    check_eq("t3_in_frame", tx_ready_a, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_a("t3");
    n = 0;
    while (!tx_ready_a && n < 100) begin
      check_eq("t3_no_start", tx_start_a, 0);
      check_eq("t3_busy_low", busy_a, 0);
      @(negedge clk);
      n++;
    end
    wait_start_a(5);
    check_eq("t3_ack1", ack1_a, 1);
    req1_a = 0;
    @(negedge clk);
    wait_idle_a(100);

    // Abort while UART blocked, then a pending request served once ready returns
    block_a = 1'b1;
    @(negedge clk);
    req1_a = 1; data1_a = 8'h77;
    @(negedge clk);
    req1_a = 0;
    for (int i = 0; i < 6; i++) begin
      check_eq("t4_no_start", tx_start_a, 0);
      check_eq("t4_no_ack1", ack1_a, 0);
      check_eq("t4_busy", busy_a, 0);
      @(negedge clk);
    end
    req0_a = 1; data0_a = 8'hC3;
    push_exp(1'b0, 8'hC3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_pending_held", tx_start_a, 0);
    end
    block_a = 1'b0;
    @(negedge clk);
    wait_start_a(5);
    req0_a = 0;
    @(negedge clk);
    wait_idle_a(100);
    check_eq("t4_drained", exp_q.size(), 0);

    // Gap of 5 on unit b: second start 7 cycles after ready re-rises
    req0_b = 1; data0_b = 8'h11;
    req1_b = 1; data1_b = 8'h22;
    n = 0;
    while (!tx_start_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_first_start", tx_start_b, 1);
    check_eq("t5_first_ack0", ack0_b, 1);
    check_eq("t5_first_data", tx_data_b, 8'h11);
    $display("TX b owner=%0d ack0=%0d ack1=%0d data=%02h", owner_b, ack0_b, ack1_b, tx_data_b);
    req0_b = 0;
    @(negedge clk);
    n = 0;
    while (!tx_ready_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    r = cyc;
    n = 0;
    while (!tx_start_b && n < 20) begin
      if (cyc - r == 3) check_eq("t5_busy_in_gap", busy_b, 1);
      @(negedge clk);
      n++;
    end
    s = cyc;
    check_eq("t5_second_start", tx_start_b, 1);
    check_eq("t5_gap_latency", s - r, 7);
    check_eq("t5_second_ack1", ack1_b, 1);
    check_eq("t5_second_data", tx_data_b, 8'h22);
    $display("TX b owner=%0d ack0=%0d ack1=%0d data=%02h", owner_b, ack0_b, ack1_b, tx_data_b);
    req1_b = 0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
